// File: rtl/enc_sched_pkg.sv
// enc_sched_pkg: K-code symbols and FSM state encoding for enc_frame_scheduler.
package enc_sched_pkg;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SOF   = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_COMMA = 3'd3;
  localparam state_t ST_EOF   = 3'd4;
  localparam state_t ST_GAP   = 3'd5;
endpackage

// File: rtl/enc_frame_scheduler.sv
// enc_frame_scheduler: frames upstream bytes into a continuous 8b/10b symbol stream (SOF/data/EOF/idle gap).
// Define ENC_SCHED_COMMA_INSERT_EN to insert a K28.5 comma after every COMMA_PERIOD data bytes.
module enc_frame_scheduler
  import enc_sched_pkg::*;
#(
  parameter int IDLE_GAP     = 2,
  parameter int COMMA_PERIOD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startin,
  input  logic [7:0] datain,
  input  logic       pushin,
  input  logic       lastin,
  output logic       readyout,
  input  logic       encstall,
  output logic [7:0] encdata,
  output logic       enck,
  output logic       encpush,
  output logic       encstart,
  output logic       busy,
  output logic       err
);
  state_t     state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic       pend_q, pend_d;
  logic [7:0] encdata_q, encdata_d;
  logic       enck_q, enck_d;
  logic       encpush_q, encpush_d;
  logic       encstart_q, encstart_d;
  logic       err_q, err_d;
  logic       adv, accept;
`ifdef ENC_SCHED_COMMA_INSERT_EN
  logic [7:0] byte_q, byte_d;
`endif

  generate
    if (IDLE_GAP < 1 || IDLE_GAP > 255 || COMMA_PERIOD < 2 || COMMA_PERIOD > 255) begin : g_bad_cfg
      $error("enc_frame_scheduler: parameter out of range");
    end
  endgenerate

  // Nothing is presented before the first post-reset edge, so stall cannot hold that edge.
  assign adv      = !encstall || !encpush_q;
  assign readyout = (state_q == ST_DATA) && !encstall;
  assign accept   = readyout && pushin;
  assign busy     = state_q != ST_IDLE;
  assign encdata  = encdata_q;
  assign enck     = enck_q;
  assign encpush  = encpush_q;
  assign encstart = encstart_q;
  assign err      = err_q;

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    pend_d     = pend_q;
    encdata_d  = encdata_q;
    enck_d     = enck_q;
    encpush_d  = encpush_q;
    encstart_d = encstart_q;
    err_d      = err_q;
`ifdef ENC_SCHED_COMMA_INSERT_EN
    byte_d     = byte_q;
`endif
    if (!adv) begin
      if (startin && !pend_q && (state_q == ST_IDLE || state_q == ST_GAP)) pend_d = 1'b1;
    end else begin
      encpush_d  = 1'b1;
      encstart_d = 1'b0;
      enck_d     = 1'b1;
      encdata_d  = K28_5;
      err_d      = startin && (pend_q || (state_q != ST_IDLE && state_q != ST_GAP));
      case (state_q)
        ST_IDLE: begin
          state_d = (startin || pend_q) ? ST_SOF : ST_IDLE;
          pend_d  = 1'b0;
        end
        ST_SOF: begin
          encdata_d  = K27_7;
          encstart_d = 1'b1;
          state_d    = ST_DATA;
`ifdef ENC_SCHED_COMMA_INSERT_EN
          byte_d     = '0;
`endif
        end
        ST_DATA: begin
          if (accept) begin
            encdata_d = datain;
            enck_d    = 1'b0;
            if (lastin) state_d = ST_EOF;
`ifdef ENC_SCHED_COMMA_INSERT_EN
            else if (byte_q == 8'(COMMA_PERIOD - 1)) begin
              state_d = ST_COMMA;
              byte_d  = '0;
            end else byte_d = byte_q + 8'd1;
`endif
          end
        end
`ifdef ENC_SCHED_COMMA_INSERT_EN
        ST_COMMA: state_d = ST_DATA;
`endif
        ST_EOF: begin
          encdata_d = K29_7;
          gap_d     = 8'(IDLE_GAP);
          state_d   = ST_GAP;
        end
        ST_GAP: begin
          gap_d   = gap_q - 8'd1;
          pend_d  = pend_q || startin;
          state_d = (gap_q == 8'd1) ? ((pend_q || startin) ? ST_SOF : ST_IDLE) : ST_GAP;
          if (gap_q == 8'd1) pend_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      pend_q     <= 1'b0;
      encdata_q  <= '0;
      enck_q     <= 1'b0;
      encpush_q  <= 1'b0;
      encstart_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef ENC_SCHED_COMMA_INSERT_EN
      byte_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      pend_q     <= pend_d;
      encdata_q  <= encdata_d;
      enck_q     <= enck_d;
      encpush_q  <= encpush_d;
      encstart_q <= encstart_d;
      err_q      <= err_d;
`ifdef ENC_SCHED_COMMA_INSERT_EN
      byte_q     <= byte_d;
`endif
    end
  end
endmodule

// File: tb/tb_enc_frame_scheduler.sv
// tb_enc_frame_scheduler: directed and randomized checks of the frame scheduler symbol stream.
module tb_enc_frame_scheduler;
  localparam int GAP = 2;
  localparam int CP  = 4;
  localparam logic [7:0] BC = 8'hBC, FB = 8'hFB, FD = 8'hFD;

  logic       clk = 1'b0;
  logic       reset;
  logic       startin, pushin, lastin, encstall;
  logic [7:0] datain;
  logic       readyout, enck, encpush, encstart, busy, err;
  logic [7:0] encdata;
  int         n_chk = 0, n_fail = 0;
  logic       mon_en = 1'b0;
  logic [9:0] capq[$];

  enc_frame_scheduler #(.IDLE_GAP(GAP), .COMMA_PERIOD(CP)) dut (
    .clk(clk), .reset(reset), .startin(startin), .datain(datain), .pushin(pushin),
    .lastin(lastin), .readyout(readyout), .encstall(encstall), .encdata(encdata),
    .enck(enck), .encpush(encpush), .encstart(encstart), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Every symbol the encoder actually consumes, as {encstart, enck, encdata}.
  always @(negedge clk)
    if (mon_en && !reset && encpush && !encstall) capq.push_back({encstart, enck, encdata});

  task automatic test_reset;
    reset = 1'b1; startin = 0; pushin = 0; lastin = 0; encstall = 0; datain = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({encdata, enck, encpush, encstart, err, busy, readyout} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h k=%b push=%b start=%b err=%b busy=%b rdy=%b, want all zero",
               encdata, enck, encpush, encstart, err, busy, readyout);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({encpush, enck, encdata, encstart, err, busy} !== {2'b11, BC, 3'b000}) begin
        n_fail++;
        $display("FAIL idle_stream[%0d]: got push=%b k=%b data=%h busy=%b, want push=1 k=1 data=bc busy=0",
                 i, encpush, enck, encdata, busy);
      end
    end
  endtask

  // Stimulus word {startin, encstall, pushin, lastin, datain}; expected word {err, encstart, enck, encdata}.
  task automatic test_frame;
    logic [11:0] st[9];
    logic [10:0] ex[9];
    st = '{12'h800, 12'h000, 12'h211, 12'h222, 12'h333, 12'h000, 12'h000, 12'h000, 12'h000};
    ex = '{11'h1BC, 11'h3FB, 11'h011, 11'h022, 11'h033, 11'h1FD, 11'h1BC, 11'h1BC, 11'h1BC};
    for (int i = 0; i < 9; i++) begin
      {startin, encstall, pushin, lastin, datain} = st[i];
      @(posedge clk); #1;
      n_chk++;
      if ({err, encstart, enck, encdata} !== ex[i] || encpush !== 1'b1) begin
        n_fail++;
        $display("FAIL frame_sym[%0d]: got {err,start,k,data}=%h push=%b, want %h", i,
                 {err, encstart, enck, encdata}, encpush, ex[i]);
      end
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_busy_after_gap: got %b want 0", busy);
    end
  endtask

  task automatic test_stall;
    logic [11:0] st[12];
    logic [10:0] ex[12];
    logic [7:0]  a, b, c;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    st = '{12'hC00, 12'h000, 12'h000, {4'h2, a}, {4'h6, b}, {4'h6, b}, {4'h6, b},
           {4'h2, b}, {4'h3, c}, 12'h000, 12'h000, 12'h000};
    ex = '{11'h1BC, 11'h1BC, 11'h3FB, {3'b000, a}, {3'b000, a}, {3'b000, a}, {3'b000, a},
           {3'b000, b}, {3'b000, c}, 11'h1FD, 11'h1BC, 11'h1BC};
    for (int i = 0; i < 12; i++) begin
      {startin, encstall, pushin, lastin, datain} = st[i];
      @(negedge clk);
      if (st[i][10]) begin
        n_chk++;
        if (readyout !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_readyout[%0d]: got %b want 0", i, readyout);
        end
      end
      @(posedge clk); #1;
      n_chk++;
      if ({err, encstart, enck, encdata} !== ex[i]) begin
        n_fail++;
        $display("FAIL stall_sym[%0d]: got %h want %h", i, {err, encstart, enck, encdata}, ex[i]);
      end
    end
    encstall = 0;
  endtask

  task automatic test_err_and_pending;
    logic [11:0] st[12];
    logic [10:0] ex[12];
    logic [7:0]  a, b, c;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    st = '{12'h800, 12'h000, {4'hA, a}, {4'h3, b}, 12'h000, 12'h800, 12'h000, 12'h000,
           {4'h3, c}, 12'h000, 12'h000, 12'h000};
    ex = '{11'h1BC, 11'h3FB, {3'b100, a}, {3'b000, b}, 11'h1FD, 11'h1BC, 11'h1BC, 11'h3FB,
           {3'b000, c}, 11'h1FD, 11'h1BC, 11'h1BC};
    for (int i = 0; i < 12; i++) begin
      {startin, encstall, pushin, lastin, datain} = st[i];
      @(posedge clk); #1;
      n_chk++;
      if ({err, encstart, enck, encdata} !== ex[i]) begin
        n_fail++;
        $display("FAIL err_pend_sym[%0d]: got %h want %h", i, {err, encstart, enck, encdata}, ex[i]);
      end
    end
  endtask

  // Expected stream built from frame rules; commas only when insertion is compiled in.
  task automatic test_long_frame;
    logic [7:0]  b[10];
    logic [10:0] q[$];
    logic [10:0] e;
    int          idx = 0, c = 0;
    bit          acc;
    for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
    q.push_back(11'h1BC);
    q.push_back(11'h3FB);
    for (int i = 0; i < 10; i++) begin
      q.push_back({3'b000, b[i]});
`ifdef ENC_SCHED_COMMA_INSERT_EN
      if ((i + 1) % CP == 0 && i != 9) q.push_back(11'h1BC);
`endif
    end
    q.push_back(11'h1FD);
    repeat (3) q.push_back(11'h1BC);
    while (q.size() > 0) begin
      startin = (c == 0); encstall = 0;
      pushin = idx < 10; datain = (idx < 10) ? b[idx] : 8'h00; lastin = idx == 9;
      @(negedge clk);
      acc = pushin && readyout;
      @(posedge clk); #1;
      e = q.pop_front();
      n_chk++;
      if ({err, encstart, enck, encdata} !== e) begin
        n_fail++;
        $display("FAIL long_frame_sym[%0d]: got %h want %h", c, {err, encstart, enck, encdata}, e);
      end
      if (acc) idx++;
      c++;
    end
    pushin = 0; lastin = 0;
  endtask

  task automatic test_random_frames;
    logic [9:0] expq[$];
    logic [7:0] b;
    int         n, idx, cyc, j, gapc;
    bit         acc, infd;
    capq.delete();
    mon_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      cyc = 0;
      while (busy && cyc < 100) begin
        encstall = $urandom_range(0, 3) == 0;
        @(posedge clk); #1;
        cyc++;
      end
      n_chk++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_wait_idle[%0d]: busy=%b after %0d cycles, want 0", f, busy, cyc);
      end
      n = $urandom_range(1, 12);
      expq.push_back({2'b11, FB});
      startin = 1; encstall = $urandom_range(0, 1) == 0;
      @(posedge clk); #1;
      startin = 0;
      idx = 0; cyc = 0; b = 8'($urandom);
      while (idx < n && cyc < 400) begin
        pushin = $urandom_range(0, 3) != 0;
        datain = b;
        lastin = pushin ? (idx == n - 1) : 1'($urandom_range(0, 1));
        encstall = $urandom_range(0, 3) == 0;
        @(negedge clk);
        acc = pushin && readyout;
        @(posedge clk); #1;
        if (acc) begin
          expq.push_back({2'b00, b});
          idx++;
          b = 8'($urandom);
        end
        cyc++;
      end
      n_chk++;
      if (idx != n) begin
        n_fail++;
        $display("FAIL rand_accept[%0d]: accepted %0d bytes, want %0d", f, idx, n);
      end
      pushin = 0; lastin = 0;
      expq.push_back({2'b01, FD});
    end
    encstall = 0;
    repeat (GAP + 6) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    j = 0; infd = 0; gapc = 0;
    foreach (capq[i]) begin
      if (capq[i] == {2'b01, BC}) begin
        if (infd) gapc++;
      end else begin
        if (capq[i] == {2'b11, FB} && infd) begin
          n_chk++;
          if (gapc < GAP) begin
            n_fail++;
            $display("FAIL rand_gap: got %0d idle symbols after EOF, want at least %0d", gapc, GAP);
          end
        end
        infd = capq[i] == {2'b01, FD};
        gapc = 0;
        n_chk++;
        if (j >= expq.size()) begin
          n_fail++;
          $display("FAIL rand_stream_extra: got %h, want no further symbols", capq[i]);
        end else if (capq[i] !== expq[j]) begin
          n_fail++;
          $display("FAIL rand_stream[%0d]: got %h want %h", j, capq[i], expq[j]);
        end
        j++;
      end
    end
    n_chk++;
    if (j != expq.size()) begin
      n_fail++;
      $display("FAIL rand_stream_len: got %0d symbols want %0d", j, expq.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [11:0] st[4];
    st = '{12'h800, 12'h000, 12'h2A1, 12'h2B2};
    for (int i = 0; i < 4; i++) begin
      {startin, encstall, pushin, lastin, datain} = st[i];
      @(posedge clk); #1;
    end
    #3 reset = 1'b1;
    #1;
    n_chk++;
    if ({encdata, enck, encpush, encstart, err, busy, readyout} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_async: got data=%h k=%b push=%b start=%b err=%b busy=%b rdy=%b, want all zero",
               encdata, enck, encpush, encstart, err, busy, readyout);
    end
    @(posedge clk); #1;
    reset = 1'b0; pushin = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({encpush, enck, encdata, busy} !== {2'b11, BC, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_resume[%0d]: got push=%b k=%b data=%h busy=%b, want 1 1 bc 0",
                 i, encpush, enck, encdata, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_frame();
    test_stall();
    test_err_and_pending();
    test_long_frame();
    test_random_frames();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/enc_frame_scheduler.md
ENC_FRAME_SCHEDULER -- requirements
Module: enc_frame_scheduler

Interface
REQ-001 Parameter IDLE_GAP, 2: minimum K28.5 idle symbols emitted after every EOF (range 1..255).
REQ-002 Parameter COMMA_PERIOD, 16: data bytes between in-frame commas (range 2..255; used only with the macro).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 startin  input  1  frame start request, sampled each cycle.
REQ-006 datain  input  8  upstream payload byte.
REQ-007 pushin  input  1  datain valid.
REQ-008 lastin  input  1  qualifies datain as final byte of frame.
REQ-009 readyout  output  1  scheduler accepts datain this cycle (combinational).
REQ-010 encstall  input  1  encoder backpressure.
REQ-011 encdata  output  8  symbol byte to encoder.
REQ-012 enck  output  1  encdata is a K-code.
REQ-013 encpush  output  1  symbol valid to encoder.
REQ-014 encstart  output  1  disparity restart strobe to encoder, coincident with SOF.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 err  output  1  one-cycle protocol-error pulse.

Function
REQ-017 FSM states SHALL be IDLE, SOF, DATA, COMMA, EOF, GAP.
REQ-018 encdata/enck/encpush/encstart/err SHALL be registered; accepted byte appears on encdata exactly 1 cycle after the accepting edge.
REQ-019 Out of reset, encpush SHALL be 1 every cycle (line never idle); a symbol is consumed when encpush=1 and encstall=0.
REQ-020 While encstall=1: state, counters and all registered outputs hold; readyout=0.
REQ-021 IDLE: emit K28.5 (0xBC, k=1); startin=1 -> SOF.
REQ-022 SOF: emit K27.7 (0xFB, k=1) with encstart=1 for that symbol only; -> DATA.
REQ-023 DATA: readyout=1 when encstall=0; pushin&readyout -> emit datain, k=0; lastin on accepted byte -> EOF.
REQ-024 DATA with pushin=0: emit K28.5 filler, state and counter unchanged, no error.
REQ-025 EOF: emit K29.7 (0xFD, k=1); load gap counter with IDLE_GAP; -> GAP.
REQ-026 GAP: emit K28.5, decrement per consumed symbol; at zero -> SOF if pending start set (then clear it), else IDLE.
REQ-027 startin in GAP SHALL set a one-deep pending flag; startin while pending already set, or in SOF/DATA/COMMA/EOF, SHALL be ignored and pulse err.
REQ-028 startin in IDLE together with encstall=1 SHALL be held as pending and honoured when stall clears.
REQ-029 lastin with pushin=0 SHALL be ignored.

Reset
REQ-030 Reset SHALL force IDLE, clear counters and pending flag; encdata=0x00, enck=0, encpush=0, encstart=0, err=0, busy=0, readyout=0.
REQ-031 Reset mid-frame SHALL abandon the frame with no EOF; first post-reset symbol is K28.5 from IDLE.

Configuration
REQ-032 Macro ENC_SCHED_COMMA_INSERT_EN defined: after COMMA_PERIOD accepted bytes without lastin, FSM SHALL enter COMMA for one symbol (K28.5, readyout=0), clear byte counter, return to DATA; counter clears at SOF.
REQ-033 Macro undefined: COMMA state and byte counter absent; frames carry unbroken data.

Structure
REQ-034 Package enc_sched_pkg SHALL hold K-code constants K28_5, K27_7, K29_7 and the state enumeration.
REQ-035 Single module; gap and byte counters inline, no sub-module.

Verification
REQ-036 Reset release, no stimulus -> encpush=1, encdata=0xBC, enck=1 every cycle, busy=0.
REQ-037 startin pulse, 3-byte frame 0x11,0x22,0x33(last), IDLE_GAP=2 -> FB(start) 11 22 33 FD BC BC then BC idle.
REQ-038 Macro on, COMMA_PERIOD=4, 6-byte frame -> SOF, 4 data, BC (readyout=0), 2 data, EOF.
REQ-039 encstall=1 for 3 cycles mid-DATA -> encdata frozen, readyout=0, no byte lost or duplicated.
REQ-040 startin during DATA -> err one-cycle pulse, frame unaffected; startin during GAP -> SOF immediately after the 2nd gap symbol.
REQ-041 reset asserted after 2nd data byte -> outputs zero asynchronously; post-release stream BC, no FD emitted.
